ex_stage_md: RTL

Parametrised execute stage for the MIPS pipeline. It keeps the existing forwarding muxes, ALU, ALU control and destination-register selection, and adds an iterative multiply/divide unit with architectural HI/LO registers. The unit implements MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO and raises a stall toward the hazard unit while a multi-cycle operation blocks a dependent instruction. It sits between the ID/EX and EX/MEM pipeline registers.

---
 rtl/ex_pkg.sv | 44 ++++
 rtl/ex_muldiv.sv | 127 ++++++++++++
 rtl/ex_stage_md.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: MD op codes, forward selects, ALU ops, MD FSM states.
package ex_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MFHI  = 4'd5,
    MD_MFLO  = 4'd6,
    MD_MTHI  = 4'd7,
    MD_MTLO  = 4'd8
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  localparam logic [1:0] FWD_REG  = 2'd0;
  localparam logic [1:0] FWD_MEM  = 2'd1;
  localparam logic [1:0] FWD_WB   = 2'd2;
  localparam logic [1:0] FWD_ZERO = 2'd3;

  // Control-unit ALU op codes; RTYPE defers to the funct field.
  localparam logic [3:0] ALUOP_ADD   = 4'd0;
  localparam logic [3:0] ALUOP_SUB   = 4'd1;
  localparam logic [3:0] ALUOP_RTYPE = 4'd2;
  localparam logic [3:0] ALUOP_AND   = 4'd3;
  localparam logic [3:0] ALUOP_OR    = 4'd4;
  localparam logic [3:0] ALUOP_XOR   = 4'd5;
  localparam logic [3:0] ALUOP_SLT   = 4'd6;
  localparam logic [3:0] ALUOP_SLTU  = 4'd7;
  localparam logic [3:0] ALUOP_LUI   = 4'd8;

  localparam int RA_IDX = 31;

  function automatic logic is_md_div(input md_op_t op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit with HI/LO: IDLE -> RUN (NB_REG/BITS_PER_CYCLE cycles) -> FIX.
// Operates on magnitudes; signs are reapplied in FIX when HI/LO are written.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int NB_REG         = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  md_op_t            op,
  input  logic [NB_REG-1:0] a,
  input  logic [NB_REG-1:0] b,
  output logic [NB_REG-1:0] hi,
  output logic [NB_REG-1:0] lo,
  output logic              stall,
  output logic              div_by_zero
);
  localparam int N    = NB_REG;
  localparam int BPC  = BITS_PER_CYCLE;
  localparam int ITER = N / BPC;
  localparam int CW   = $clog2(ITER + 1);

  md_state_t        state;
  logic [CW-1:0]    cnt;
  logic             is_div, neg_lo, neg_hi, dz;
  logic [N-1:0]     b_mag_q;
  logic [2*N-1:0]   acc, acc_step, prod;
  logic             is_signed, a_neg, b_neg, start;
  logic [N-1:0]     a_mag, b_mag, q_fix, r_fix;
  logic [N-1:0]     rem, quo;
  logic [N:0]       rem_w;
  logic [N+BPC-1:0] psum;

  assign stall     = valid & (op != MD_NONE) & (state != MD_IDLE);
  assign start     = valid & (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU}) &
                     (state == MD_IDLE) & ~stall;
  assign is_signed = (op == MD_MULT) | (op == MD_DIV);
  assign a_neg     = is_signed & a[N-1];
  assign b_neg     = is_signed & b[N-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  always_comb begin
    acc_step = acc;
    rem      = acc[2*N-1:N];
    quo      = acc[N-1:0];
    rem_w    = '0;
    psum     = '0;
    if (is_div) begin
      for (int i = 0; i < BPC; i++) begin
        rem_w = {rem, quo[N-1]};
        quo   = {quo[N-2:0], 1'b0};
        if (rem_w >= {1'b0, b_mag_q}) begin
          rem_w  = rem_w - {1'b0, b_mag_q};
          quo[0] = 1'b1;
        end
        rem = rem_w[N-1:0];
      end
      acc_step = {rem, quo};
    end else begin
      psum     = {{BPC{1'b0}}, acc[2*N-1:N]} +
                 ({{BPC{1'b0}}, b_mag_q} * (N+BPC)'(acc[BPC-1:0]));
      acc_step = {psum, acc[N-1:BPC]};
    end
  end

  assign prod  = neg_lo ? -acc : acc;
  assign q_fix = dz ? '1 : (neg_lo ? -acc[N-1:0] : acc[N-1:0]);
  assign r_fix = neg_hi ? -acc[2*N-1:N] : acc[2*N-1:N];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MD_IDLE;
      cnt         <= '0;
      hi          <= '0;
      lo          <= '0;
      acc         <= '0;
      b_mag_q     <= '0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      dz          <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      div_by_zero <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (start) begin
            acc     <= {{N{1'b0}}, a_mag};
            b_mag_q <= b_mag;
            is_div  <= is_md_div(op);
            neg_lo  <= a_neg ^ b_neg;
            neg_hi  <= a_neg;
            dz      <= is_md_div(op) && (b == '0);
            cnt     <= CW'(ITER);
            state   <= MD_RUN;
          end else if (valid && op == MD_MTHI) begin
            hi <= a;
          end else if (valid && op == MD_MTLO) begin
            lo <= a;
          end
        end
        MD_RUN: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= MD_FIX;
        end
        MD_FIX: begin
          if (is_div) begin
            hi          <= r_fix;
            lo          <= q_fix;
            div_by_zero <= dz;
          end else begin
            hi <= prod[2*N-1:N];
            lo <= prod[N-1:0];
          end
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_md.sv
// MIPS execute stage: forwarding muxes, ALU control + ALU, destination mux, and the MD unit.
// ALU path is combinational; MD ops stall dependent instructions while the unit is busy.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int NB_REG         = 32,
  parameter int NB_ADDR        = 5,
  parameter int ALU_OP         = 4,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_alu_src,
  input  logic               i_reg_dst,
  input  logic               i_jal_sel,
  input  logic [ALU_OP-1:0]  i_alu_op,
  input  logic [5:0]         i_funct,
  input  logic [3:0]         i_md_op,
  input  logic [NB_REG-1:0]  i_rs_data,
  input  logic [NB_REG-1:0]  i_rt_data,
  input  logic [NB_REG-1:0]  i_imm,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  input  logic [NB_ADDR-1:0] i_rt_addr,
  input  logic [NB_REG-1:0]  i_fwd_mem,
  input  logic [NB_REG-1:0]  i_fwd_wb,
  input  logic [1:0]         i_forward_a,
  input  logic [1:0]         i_forward_b,
  output logic [NB_REG-1:0]  o_result,
  output logic [NB_REG-1:0]  o_store_data,
  output logic [NB_ADDR-1:0] o_write_reg,
  output logic               o_zero,
  output logic               o_stall,
  output logic               o_div_by_zero
);
  localparam int SHW = $clog2(NB_REG);

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLV, ALU_SRLV, ALU_SRAV, ALU_LUI
  } alu_ctl_t;

  md_op_t            md_op;
  alu_ctl_t          ctl;
  logic [NB_REG-1:0] opa, fwd_b, opb, alu_res, hi, lo;
  logic [SHW-1:0]    shamt;

  assign md_op = md_op_t'(i_md_op);
  assign shamt = i_imm[SHW+5:6];

  always_comb begin
    case (i_forward_a)
      FWD_REG: opa = i_rs_data;
      FWD_MEM: opa = i_fwd_mem;
      FWD_WB:  opa = i_fwd_wb;
      default: opa = '0;
    endcase
    case (i_forward_b)
      FWD_REG: fwd_b = i_rt_data;
      FWD_MEM: fwd_b = i_fwd_mem;
      FWD_WB:  fwd_b = i_fwd_wb;
      default: fwd_b = '0;
    endcase
  end

  assign opb          = i_alu_src ? i_imm : fwd_b;
  assign o_store_data = fwd_b;

  always_comb begin
    ctl = ALU_ADD;
    case (i_alu_op)
      ALU_OP'(ALUOP_SUB):  ctl = ALU_SUB;
      ALU_OP'(ALUOP_AND):  ctl = ALU_AND;
      ALU_OP'(ALUOP_OR):   ctl = ALU_OR;
      ALU_OP'(ALUOP_XOR):  ctl = ALU_XOR;
      ALU_OP'(ALUOP_SLT):  ctl = ALU_SLT;
      ALU_OP'(ALUOP_SLTU): ctl = ALU_SLTU;
      ALU_OP'(ALUOP_LUI):  ctl = ALU_LUI;
      ALU_OP'(ALUOP_RTYPE): begin
        case (i_funct)
          6'h22, 6'h23: ctl = ALU_SUB;
          6'h24:        ctl = ALU_AND;
          6'h25:        ctl = ALU_OR;
          6'h26:        ctl = ALU_XOR;
          6'h27:        ctl = ALU_NOR;
          6'h2A:        ctl = ALU_SLT;
          6'h2B:        ctl = ALU_SLTU;
          6'h00:        ctl = ALU_SLL;
          6'h02:        ctl = ALU_SRL;
          6'h03:        ctl = ALU_SRA;
          6'h04:        ctl = ALU_SLLV;
          6'h06:        ctl = ALU_SRLV;
          6'h07:        ctl = ALU_SRAV;
          default:      ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
  end

  always_comb begin
    case (ctl)
      ALU_SUB:  alu_res = opa - opb;
      ALU_AND:  alu_res = opa & opb;
      ALU_OR:   alu_res = opa | opb;
      ALU_XOR:  alu_res = opa ^ opb;
      ALU_NOR:  alu_res = ~(opa | opb);
      ALU_SLT:  alu_res = {{(NB_REG-1){1'b0}}, $signed(opa) < $signed(opb)};
      ALU_SLTU: alu_res = {{(NB_REG-1){1'b0}}, opa < opb};
      ALU_SLL:  alu_res = opb << shamt;
      ALU_SRL:  alu_res = opb >> shamt;
      ALU_SRA:  alu_res = $signed(opb) >>> shamt;
      ALU_SLLV: alu_res = opb << opa[SHW-1:0];
      ALU_SRLV: alu_res = opb >> opa[SHW-1:0];
      ALU_SRAV: alu_res = $signed(opb) >>> opa[SHW-1:0];
      ALU_LUI:  alu_res = opb << (NB_REG / 2);
      default:  alu_res = opa + opb;
    endcase
  end

  assign o_zero      = (alu_res == '0);
  assign o_result    = (md_op == MD_MFHI) ? hi : (md_op == MD_MFLO) ? lo : alu_res;
  assign o_write_reg = i_jal_sel ? NB_ADDR'(RA_IDX) : (i_reg_dst ? i_rd_addr : i_rt_addr);

  ex_muldiv #(
    .NB_REG         (NB_REG),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_muldiv (
    .clk         (i_clk),
    .rst         (i_rst),
    .valid       (i_valid),
    .op          (md_op),
    .a           (opa),
    .b           (fwd_b),
    .hi          (hi),
    .lo          (lo),
    .stall       (o_stall),
    .div_by_zero (o_div_by_zero)
  );

endmodule
